// File: rtl/hydra_pkg.sv
// Shared sizes, index types and candidate record for the SRAM write allocator.
// The fit test widens both operands by one bit so a 64-page packet never wraps.
package hydra_pkg;

   localparam int NUM_PORTS = 16;
   localparam int NUM_SRAMS = 32;
   localparam int SPACE_W   = 11;
   localparam int LEN_W     = 6;
   localparam int PORT_W    = 4;
   localparam int SRAM_W    = 5;

   typedef logic [PORT_W-1:0] port_idx_t;
   typedef logic [SRAM_W-1:0] sram_idx_t;

   typedef enum logic {
      IDLE  = 1'b0,
      BOUND = 1'b1
   } bind_state_e;

   typedef struct packed {
      logic                 valid;
      logic [SPACE_W-1:0]   space;
      sram_idx_t            idx;
   } cand_t;

   // len holds pages-1, so the packet needs len+1 pages
   function automatic logic fits(input logic [SPACE_W-1:0] space,
                                 input logic [LEN_W-1:0]   len);
      logic [SPACE_W:0] need;
      need = {{(SPACE_W+1-LEN_W){1'b0}}, len} + {{SPACE_W{1'b0}}, 1'b1};
      return {1'b0, space} >= need;
   endfunction

endpackage

// File: rtl/sram_select_tree.sv
// Combinational max-free-space picker over the eligible SRAMs.
// Heap-ordered binary tree: node k has children 2k (lower indices) and 2k+1.
module sram_select_tree
   import hydra_pkg::*;
(
   input  logic [NUM_SRAMS-1:0]         elig,
   input  logic [NUM_SRAMS*SPACE_W-1:0] free_space,
   output logic                         win_vld,
   output logic [SRAM_W-1:0]            win_idx
);

   cand_t node [2*NUM_SRAMS];

   // left operand covers lower indices, so it wins ties
   function automatic cand_t pick(input cand_t a, input cand_t b);
      if (a.valid && (!b.valid || a.space >= b.space)) begin
         return a;
      end
      return b;
   endfunction

   always_comb begin
      node[0] = '0;
      for (int s = 0; s < NUM_SRAMS; s++) begin
         node[NUM_SRAMS+s].valid = elig[s];
         node[NUM_SRAMS+s].space = free_space[s*SPACE_W +: SPACE_W];
         node[NUM_SRAMS+s].idx   = sram_idx_t'(s);
      end
      for (int k = NUM_SRAMS-1; k >= 1; k--) begin
         node[k] = pick(node[2*k], node[2*k+1]);
      end
   end

   assign win_vld = node[1].valid;
   assign win_idx = node[1].idx;

endmodule

// File: rtl/sram_write_allocator.sv
// Binds ingress packets to SRAM banks: one grant per cycle, round-robin over
// ports, largest-free-space bank wins; the binding holds until the port's eop.
module sram_write_allocator
   import hydra_pkg::*;
(
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_PORTS-1:0]         req,
   input  logic [NUM_PORTS*LEN_W-1:0]   req_len,
   input  logic [NUM_PORTS-1:0]         eop,
   input  logic [NUM_SRAMS*SPACE_W-1:0] free_space,
   output logic                         grant_vld,
   output logic [PORT_W-1:0]            grant_port,
   output logic [SRAM_W-1:0]            grant_sram,
   output logic [NUM_PORTS-1:0]         port_bound,
   output logic [NUM_PORTS*SRAM_W-1:0]  port_sram,
   output logic [NUM_SRAMS-1:0]         sram_busy
);

   bind_state_e bind_st  [NUM_PORTS];
   sram_idx_t   own_sram [NUM_PORTS];
   port_idx_t   rr_ptr;

   logic [NUM_PORTS-1:0]   cand_p0;
   logic [2*NUM_PORTS-1:0] cand_dbl_p0;
   logic                   sel_vld_p0;
   port_idx_t              sel_port_p0;
   logic [LEN_W-1:0]       sel_len_p0;
   logic [NUM_SRAMS-1:0]   elig_p0;
   logic                   win_vld_p0;
   logic [SRAM_W-1:0]      win_idx_p0;
   logic                   grant_p0;

   always_comb begin
      for (int p = 0; p < NUM_PORTS; p++) begin
         port_bound[p]                 = (bind_st[p] == BOUND);
         port_sram[p*SRAM_W +: SRAM_W] = own_sram[p];
      end
   end

   // ---- stage p0: round-robin port select and bank eligibility ----
   assign cand_p0 = req & ~port_bound;

   // lower copy masked below rr_ptr, upper copy supplies the wrap-around
   assign cand_dbl_p0 = {cand_p0, cand_p0 & ({NUM_PORTS{1'b1}} << rr_ptr)};

   always_comb begin
      sel_vld_p0  = 1'b0;
      sel_port_p0 = '0;
      for (int i = 2*NUM_PORTS-1; i >= 0; i--) begin
         if (cand_dbl_p0[i]) begin
            sel_vld_p0  = 1'b1;
            sel_port_p0 = port_idx_t'(i % NUM_PORTS);
         end
      end
   end

   assign sel_len_p0 = req_len[sel_port_p0*LEN_W +: LEN_W];

   always_comb begin
      for (int s = 0; s < NUM_SRAMS; s++) begin
         elig_p0[s] = ~sram_busy[s] & fits(free_space[s*SPACE_W +: SPACE_W], sel_len_p0);
      end
   end

   sram_select_tree u_select (
      .elig       (elig_p0),
      .free_space (free_space),
      .win_vld    (win_vld_p0),
      .win_idx    (win_idx_p0)
   );

   assign grant_p0 = sel_vld_p0 & win_vld_p0;

   // ---- stage p1: binding state update ----
   // A released bank stays busy through its eop cycle, and a granted bank is
   // idle by construction, so release and grant never touch the same bit.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         grant_vld  <= 1'b0;
         grant_port <= '0;
         grant_sram <= '0;
         sram_busy  <= '0;
         rr_ptr     <= '0;
         for (int p = 0; p < NUM_PORTS; p++) begin
            bind_st[p]  <= IDLE;
            own_sram[p] <= '0;
         end
      end else begin
         grant_vld <= grant_p0;
         if (sel_vld_p0) begin
            rr_ptr <= port_idx_t'(sel_port_p0 + 4'd1);
         end
         for (int p = 0; p < NUM_PORTS; p++) begin
            if (eop[p] && bind_st[p] == BOUND) begin
               bind_st[p]            <= IDLE;
               sram_busy[own_sram[p]] <= 1'b0;
            end
         end
         if (grant_p0) begin
            grant_port            <= sel_port_p0;
            grant_sram            <= win_idx_p0;
            bind_st[sel_port_p0]  <= BOUND;
            own_sram[sel_port_p0] <= win_idx_p0;
            sram_busy[win_idx_p0] <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_sram_write_allocator.sv
// Bench for sram_write_allocator: directed scenarios plus randomized traffic
// against a behavioural binding model (owner table, rotating port search).
module tb_sram_write_allocator;

   localparam int NP = 16;
   localparam int NS = 32;
   localparam int SW = 11;
   localparam int LW = 6;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [NP-1:0]   req;
   logic [NP*LW-1:0] req_len;
   logic [NP-1:0]   eop;
   logic [NS*SW-1:0] free_space;
   logic            grant_vld;
   logic [3:0]      grant_port;
   logic [4:0]      grant_sram;
   logic [NP-1:0]   port_bound;
   logic [NP*5-1:0] port_sram;
   logic [NS-1:0]   sram_busy;

   sram_write_allocator dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req),
      .req_len    (req_len),
      .eop        (eop),
      .free_space (free_space),
      .grant_vld  (grant_vld),
      .grant_port (grant_port),
      .grant_sram (grant_sram),
      .port_bound (port_bound),
      .port_sram  (port_sram),
      .sram_busy  (sram_busy)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // model state
   bit m_bound [NP];
   int m_owner [NP];
   int m_rr;
   bit m_gvld;
   int m_gport;
   int m_gsram;
   bit m_was_rst;

   // fairness tracking
   bit fair_on = 1'b0;
   int wait_cnt [NP];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int fs_of(input int s);
      return int'(free_space[s*SW +: SW]);
   endfunction

   task automatic set_fs_all(input int v);
      for (int s = 0; s < NS; s++) free_space[s*SW +: SW] = SW'(v);
   endtask

   task automatic set_len(input int p, input int l);
      req_len[p*LW +: LW] = LW'(l);
   endtask

   // next-state of the binding model from the current inputs
   task automatic model_step();
      bit busy [NS];
      int sel;
      int best;
      int len;
      if (!rst_n) begin
         for (int p = 0; p < NP; p++) begin
            m_bound[p] = 0;
            m_owner[p] = 0;
         end
         m_rr = 0; m_gvld = 0; m_gport = 0; m_gsram = 0; m_was_rst = 1;
         return;
      end
      m_was_rst = 0;
      for (int s = 0; s < NS; s++) busy[s] = 0;
      for (int p = 0; p < NP; p++) if (m_bound[p]) busy[m_owner[p]] = 1;
      sel = -1;
      for (int k = 0; k < NP; k++) begin
         int p;
         p = (m_rr + k) % NP;
         if (sel < 0 && req[p] && !m_bound[p]) sel = p;
      end
      best = -1;
      if (sel >= 0) begin
         len = int'(req_len[sel*LW +: LW]);
         for (int s = 0; s < NS; s++) begin
            if (!busy[s] && fs_of(s) >= len + 1 && (best < 0 || fs_of(s) > fs_of(best)))
               best = s;
         end
      end
      for (int p = 0; p < NP; p++) if (eop[p] && m_bound[p]) m_bound[p] = 0;
      m_gvld = 0;
      if (sel >= 0 && best >= 0) begin
         m_bound[sel] = 1;
         m_owner[sel] = best;
         m_gvld  = 1;
         m_gport = sel;
         m_gsram = best;
      end
      if (sel >= 0) m_rr = (sel + 1) % NP;
   endtask

   task automatic check_all();
      logic [NP-1:0] exp_bound;
      logic [NS-1:0] exp_busy;
      bit dup;
      exp_bound = '0;
      exp_busy  = '0;
      for (int p = 0; p < NP; p++) begin
         exp_bound[p] = m_bound[p];
         if (m_bound[p]) exp_busy[m_owner[p]] = 1'b1;
      end
      chk("grant_vld", grant_vld, m_gvld);
      if (m_gvld || m_was_rst) begin
         chk("grant_port", grant_port, m_gport);
         chk("grant_sram", grant_sram, m_gsram);
      end
      chk("port_bound", port_bound, exp_bound);
      chk("sram_busy", sram_busy, exp_busy);
      if (m_was_rst) begin
         chk("port_sram_rst", port_sram, 0);
      end else begin
         for (int p = 0; p < NP; p++)
            if (m_bound[p]) chk("port_sram", port_sram[p*5 +: 5], m_owner[p]);
      end
      dup = 0;
      for (int p = 0; p < NP; p++)
         for (int q = p + 1; q < NP; q++)
            if (port_bound[p] && port_bound[q] && port_sram[p*5 +: 5] == port_sram[q*5 +: 5])
               dup = 1;
      chk("no_double_bind", dup, 0);
   endtask

   task automatic step();
      bit waiting [NP];
      for (int p = 0; p < NP; p++) waiting[p] = rst_n && req[p] && !m_bound[p];
      model_step();
      @(posedge clk);
      #1;
      check_all();
      if (fair_on) begin
         for (int p = 0; p < NP; p++) begin
            if (waiting[p]) begin
               wait_cnt[p]++;
               if (m_bound[p]) begin
                  chk("fair_wait", wait_cnt[p] <= NP, 1);
                  wait_cnt[p] = 0;
               end else if (wait_cnt[p] == NP + 1) begin
                  chk("fair_wait_timeout", wait_cnt[p], NP);
               end
            end else begin
               wait_cnt[p] = 0;
            end
         end
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; req = '0; eop = '0; req_len = '0;
      set_fs_all(2047);
      for (int p = 0; p < NP; p++) wait_cnt[p] = 0;
      step();
      step();
      chk("rst_grant_vld", grant_vld, 0);
      chk("rst_port_bound", port_bound, 0);
      chk("rst_sram_busy", sram_busy, 0);
      rst_n = 1'b1;

      // single request, all banks empty: lowest index wins the tie
      req[3] = 1'b1; set_len(3, 5);
      step();
      chk("t1_vld", grant_vld, 1);
      chk("t1_port", grant_port, 3);
      chk("t1_sram", grant_sram, 0);
      chk("t1_busy0", sram_busy[0], 1);
      chk("t1_model_sram", m_gsram, 0);
      req = '0; step();
      eop[3] = 1'b1; step(); eop = '0;

      // largest bank wins; 64-page packet needs 64 pages
      set_fs_all(50); free_space[7*SW +: SW] = 11'd100;
      req[0] = 1'b1; set_len(0, 63);
      step();
      chk("t2_vld", grant_vld, 1);
      chk("t2_sram", grant_sram, 7);
      chk("t2_model_sram", m_gsram, 7);
      req = '0; eop[0] = 1'b1; step(); eop = '0;

      // nothing fits: no grant, pointer still moves past port 1
      set_fs_all(63);
      req[1] = 1'b1; set_len(1, 63);
      step();
      chk("t2_nofit_vld", grant_vld, 0);
      set_fs_all(2047);
      req[2] = 1'b1; set_len(1, 0); set_len(2, 0);
      step();
      chk("t2_rr_port", grant_port, 2);
      chk("t2_rr_model", m_gport, 2);
      step();
      chk("t2_rr_next", grant_port, 1);
      req = '0; eop[1] = 1'b1; eop[2] = 1'b1; step(); eop = '0;

      // all ports at once from a fresh pointer
      do_reset();
      req = '1;
      for (int p = 0; p < NP; p++) set_len(p, $urandom_range(0, 63));
      for (int i = 0; i < NP; i++) begin
         step();
         chk("t3_port", grant_port, i);
         chk("t3_sram", grant_sram, i);
      end
      req = '0; step();
      eop = '1; step(); eop = '0;

      // release and request in the same cycle: released bank reused a cycle later
      do_reset();
      set_fs_all(0); free_space[9*SW +: SW] = 11'd2047;
      req[2] = 1'b1; set_len(2, 0);
      step();
      chk("t4_bind_sram", grant_sram, 9);
      req = '0; eop[2] = 1'b1; req[5] = 1'b1; set_len(5, 3);
      step();
      chk("t4_hold_vld", grant_vld, 0);
      eop = '0;
      step();
      chk("t4_vld", grant_vld, 1);
      chk("t4_port", grant_port, 5);
      chk("t4_sram", grant_sram, 9);
      req = '0; eop[5] = 1'b1; step(); eop = '0;

      // reset with four live bindings
      set_fs_all(2047);
      req = 16'h1111;
      for (int i = 0; i < 4; i++) step();
      chk("t5_bound", port_bound, 16'h1111);
      req = '0;
      do_reset();
      chk("t5_rst_bound", port_bound, 0);
      chk("t5_rst_busy", sram_busy, 0);
      chk("t5_rst_vld", grant_vld, 0);

      // random traffic, banks always roomy: every waiting port served in time
      fair_on = 1'b1;
      for (int c = 0; c < 1500; c++) begin
         for (int p = 0; p < NP; p++) begin
            eop[p] = 1'b0;
            if (m_bound[p]) begin
               if (req[p] && $urandom_range(0, 1) == 0) req[p] = 1'b0;
               eop[p] = ($urandom_range(0, 5) == 0);
            end else begin
               if (!req[p] && $urandom_range(0, 3) == 0) begin
                  req[p] = 1'b1;
                  set_len(p, $urandom_range(0, 63));
               end
               eop[p] = ($urandom_range(0, 19) == 0);
            end
         end
         step();
      end
      fair_on = 1'b0;

      // random traffic with tight, changing free space and a mid-run reset
      for (int c = 0; c < 1500; c++) begin
         for (int s = 0; s < NS; s++)
            free_space[s*SW +: SW] = ($urandom_range(0, 7) == 0) ?
                                     SW'($urandom_range(0, 2047)) : SW'($urandom_range(0, 90));
         for (int p = 0; p < NP; p++) begin
            if (!m_bound[p] && !req[p]) begin
               req[p] = ($urandom_range(0, 2) == 0);
               set_len(p, $urandom_range(0, 63));
            end else if (m_bound[p]) begin
               req[p] = ($urandom_range(0, 3) == 0);
            end
            eop[p] = ($urandom_range(0, 4) == 0);
         end
         rst_n = (c != 700);
         step();
      end
      rst_n = 1'b1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
